alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one registered ALU (one-cycle latency: `aluop`/`a`/`b` sampled on a clock edge, `f` valid after that edge) between `NUM_REQ` requesters. Requests are selected round-robin and issued to the ALU at up to one per cycle. Results are captured into a 2-entry response FIFO and returned on a single valid/ready response channel tagged with the requester ID. The block sits between the issuing units and the ALU instance and owns all drive of the ALU inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester ID (localparam).
- `clk`  in  1  clock, shared with the ALU.
- `rst_n`  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `req_valid`  in  `[NUM_REQ]`  request pending.
- `req_ready`  out  `[NUM_REQ]`  request accepted this cycle.
- `req_aluop`  in  `[NUM_REQ][3]`  ALU opcode: 000 add, 001 sll, 010 sra, 011 sub, 100 xor, 101 srl, 110 or, 111 and.
- `req_a`, `req_b`  in  `[NUM_REQ][32]`  operands.
- `alu_aluop`  out  3  to ALU.
- `alu_a`, `alu_b`  out  32  to ALU.
- `alu_f`  in  32  from ALU, registered.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  consumer accepts.
- `resp_id`  out  `ID_W`  index of the originating requester.
- `resp_f`  out  32  result.

## Operation
- Issue credit rule: `issue_ok = (fifo_count + inflight - resp_fire) < 2`, where `resp_fire = resp_valid & resp_ready`.
- Arbitration:
  - Round-robin over `req_valid`, searching from `rr_ptr`.
  - When a winner `g` is granted and `issue_ok` is true, `req_ready[g] = 1` and all other bits are 0.
  - `req_ready` is combinational from `req_valid`, `rr_ptr` and the credit state.
- On handshake (`req_valid[g] & req_ready[g]`):
  - `alu_*` are driven combinationally from requester `g`.
  - At the clock edge: `inflight <= 1`, `inflight_id <= g`, `rr_ptr <= (g+1) mod NUM_REQ`.
- With no handshake: `alu_*` are driven to 0, `inflight <= 0`, `rr_ptr` holds. The ALU still computes, but that result is never captured.
- When `inflight` is 1: `{inflight_id, alu_f}` is pushed into the FIFO at the clock edge. Because the credit rule is enforced, the push can never overflow.
- FIFO:
  - 2 entries, first-in first-out.
  - The head drives `resp_id`/`resp_f`; `resp_valid = (fifo_count != 0)`.
  - A push and a pop in the same cycle are both performed; count is unchanged.
- Requester contract: `req_valid` and its payload stay stable until `req_ready`. A requester may drop `req_valid` before grant; this is not an error and nothing is issued for it.
- Response contract: the head entry and `resp_valid` stay stable until `resp_fire`.
- Width rules: operands and results are 32-bit, passed through unmodified. Shift amount is `b[4:0]`, handled by the ALU.

## Timing
- Reset values (asynchronous, all outputs and state):
  - `req_ready` = 0 (`req_valid` is ignored while `rst_n` = 0).
  - `alu_aluop` = 0, `alu_a` = 0, `alu_b` = 0.
  - `resp_valid` = 0, `resp_id` = 0, `resp_f` = 0.
  - `inflight` = 0, `fifo_count` = 0, `rr_ptr` = 0.
- Latency: handshake in cycle N → ALU edge at end of N → push at end of N+1 → `resp_valid` = 1 in cycle N+2.
- Throughput: 1 op/cycle when `resp_ready` is held high.
- Backpressure, with `resp_ready` = 0:
  - At most 2 further issues are accepted.
  - `req_ready` is then all 0 until a pop occurs.
  - Same-cycle credit: a pop in cycle N permits an issue in cycle N.
- Simultaneous events: all requesters valid → grants rotate 0,1,2,3,0,… with one grant per cycle.
- Reset mid-operation: the in-flight op and FIFO contents are discarded. No response is produced for them.
- ALU has no reset: `alu_f` is garbage until the first capture and must never be pushed without `inflight` = 1.

## Configuration
- `ALU_ARB_STALL_CNT_EN` defined:
  - Adds output `stall_cnt` (32 bits, reset 0).
  - Increments each cycle where `|req_valid & ~issue_ok`.
  - Saturates at `32'hFFFF_FFFF`.
- Not defined: the port and counter do not exist; behaviour is otherwise identical.

## Structure
- Shared package `alu_pkg`:
  - `alu_ops_t` enum, covering the eight opcodes above.
  - `alu_req_t` struct {aluop, a, b}.
  - `alu_resp_t` struct {id, f}; `ID_W` is parameterised at the module level.
- Sub-module `rr_arbiter`:
  - Parameter `N`.
  - Inputs `req[N]`, `ptr`, `en`.
  - Outputs: one-hot `gnt[N]` and encoded `gnt_idx`; purely combinational.
  - The pointer register stays in `alu_arbiter`.
- FIFO is inline: 2 entries plus a 2-bit count.

## Test plan
- Single request: req0 `aluop` 000, a=5, b=7 in cycle 0 → cycle 2: `resp_valid` = 1, `resp_id` = 0, `resp_f` = 12.
- Contention: all four valid, each with op 011, a=100, b=k (k = requester index) → responses in id order 0,1,2,3 with f = 100,99,98,97. This is back-to-back, one per cycle from cycle 2.
- Backpressure:
  - `resp_ready` = 0 with req1 streaming → exactly 2 handshakes, then `req_ready` = 0.
  - Raise `resp_ready` → responses arrive in order, none lost or duplicated.
- Sign/shift: op 010, a=`32'h8000_0000`, b=`32'h24` → f = `32'hF800_0000`; op 101 with the same operands → `32'h0800_0000`.
- Reset mid-operation: assert `rst_n` = 0 asynchronously while one op is in flight and the FIFO holds 1 entry → all outputs read 0 immediately, and no response appears after release.
- Stall counter (with `ALU_ARB_STALL_CNT_EN`): hold `resp_ready` = 0 and req0 valid for 10 cycles → `stall_cnt` = 8.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU types: opcode encoding and request/response payloads.
// Used by the arbiter, its interface and any block that talks to the ALU.
package alu_pkg;

  localparam int unsigned ALU_W        = 32;
  localparam int unsigned ALU_OP_W     = 3;
  localparam int unsigned ALU_ID_MAX_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SLL = 3'b001,
    ALU_SRA = 3'b010,
    ALU_SUB = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SRL = 3'b101,
    ALU_OR  = 3'b110,
    ALU_AND = 3'b111
  } alu_ops_t;

  typedef struct packed {
    alu_ops_t         aluop;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
  } alu_req_t;

  // id is sized for the largest requester count; users narrow it to their ID_W.
  typedef struct packed {
    logic [ALU_ID_MAX_W-1:0] id;
    logic [ALU_W-1:0]        f;
  } alu_resp_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, ALU and response channels of alu_arbiter.
// slave: the arbiter's view; master: the requesters/consumer/ALU environment.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
);

  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ-1:0][ALU_OP_W-1:0]  req_aluop;
  logic [NUM_REQ-1:0][ALU_W-1:0]     req_a;
  logic [NUM_REQ-1:0][ALU_W-1:0]     req_b;

  logic [ALU_OP_W-1:0]               alu_aluop;
  logic [ALU_W-1:0]                  alu_a;
  logic [ALU_W-1:0]                  alu_b;
  logic [ALU_W-1:0]                  alu_f;

  logic                              resp_valid;
  logic                              resp_ready;
  logic [ID_W-1:0]                   resp_id;
  logic [ALU_W-1:0]                  resp_f;

  modport slave (
    input  req_valid, req_aluop, req_a, req_b, alu_f, resp_ready,
    output req_ready, alu_aluop, alu_a, alu_b, resp_valid, resp_id, resp_f
  );

  modport master (
    output req_valid, req_aluop, req_a, req_b, alu_f, resp_ready,
    input  req_ready, alu_aluop, alu_a, alu_b, resp_valid, resp_id, resp_f
  );

endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping.
// gnt/gnt_idx are zero when en is low or nothing is requested.
module rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic             found;
  logic [IDX_W-1:0] win;
  int unsigned      k;

  always_comb begin
    found   = 1'b0;
    win     = '0;
    k       = 0;
    gnt     = '0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (32'(ptr) + i) % N;
      if (!found && req[IDX_W'(k)]) begin
        found = 1'b1;
        win   = IDX_W'(k);
      end
    end
    if (en && found) begin
      gnt[win] = 1'b1;
      gnt_idx  = win;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU among NUM_REQ requesters: round-robin issue, 2-entry response FIFO.
// Optional feature: define ALU_ARB_STALL_CNT_EN to add the saturating stall_cnt output.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
`ifdef ALU_ARB_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  localparam int unsigned ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 2;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    rr_ptr_nxt;
  logic [ID_W-1:0]    inflight_id;
  logic               inflight;
  logic               issue_ok;
  logic               arb_en;
  logic               hs;
  logic               resp_fire;
  logic               push;
  alu_req_t           issue_req;

  logic [CNT_W-1:0]   fifo_count;
  logic               rd_ptr;
  logic               wr_ptr;
  logic [ID_W-1:0]    fifo_id [FIFO_DEPTH];
  logic [ALU_W-1:0]   fifo_f  [FIFO_DEPTH];

  assign resp_fire = bus.resp_valid & bus.resp_ready;

  // Occupied slots (FIFO + in-flight) minus this cycle's pop must leave room for one more.
  assign issue_ok = (3'(fifo_count) + 3'(inflight)) < (3'd2 + 3'(resp_fire));
  assign arb_en   = issue_ok & rst_n;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign bus.req_ready = gnt;
  assign hs            = |gnt;
  assign rr_ptr_nxt    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

  // ALU inputs follow the winner during a handshake and are zero otherwise.
  always_comb begin
    issue_req = '0;
    if (hs) begin
      issue_req.aluop = alu_ops_t'(bus.req_aluop[gnt_idx]);
      issue_req.a     = bus.req_a[gnt_idx];
      issue_req.b     = bus.req_b[gnt_idx];
    end
  end

  assign bus.alu_aluop = issue_req.aluop;
  assign bus.alu_a     = issue_req.a;
  assign bus.alu_b     = issue_req.b;

  // Issue tracking: one op can be in the ALU pipeline stage at a time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight    <= 1'b0;
      inflight_id <= '0;
      rr_ptr      <= '0;
    end else begin
      inflight <= hs;
      if (hs) begin
        inflight_id <= gnt_idx;
        rr_ptr      <= rr_ptr_nxt;
      end
    end
  end

  assign push = inflight;

  // Response FIFO; the credit rule guarantees push never hits a full FIFO without a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_count <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_id[i] <= '0;
        fifo_f[i]  <= '0;
      end
    end else begin
      if (push) begin
        fifo_id[wr_ptr] <= inflight_id;
        fifo_f[wr_ptr]  <= bus.alu_f;
        wr_ptr          <= ~wr_ptr;
      end
      if (resp_fire) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, resp_fire})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign bus.resp_valid = (fifo_count != '0);
  assign bus.resp_id    = fifo_id[rd_ptr];
  assign bus.resp_f     = fifo_f[rd_ptr];

`ifdef ALU_ARB_STALL_CNT_EN
  // Cycles where someone wants to issue but no credit is available; saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((|bus.req_valid) && !issue_ok && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vectors, corner sequences, random traffic.
// Includes a behavioural registered ALU and a queue-based scoreboard of outstanding ops.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned NREQ = 4;

  logic clk;
  logic rst_n;

  alu_arbiter_if #(.NUM_REQ(NREQ)) bus ();

`ifdef ALU_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  alu_arbiter #(.NUM_REQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus)
`ifdef ALU_ARB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Environment ALU: one-cycle registered, operator-based.
  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a << b[4:0];
      3'b010:  return 32'($signed(a) >>> b[4:0]);
      3'b011:  return a - b;
      3'b100:  return a ^ b;
      3'b101:  return a >> b[4:0];
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  always_ff @(posedge clk) bus.alu_f <= alu_fn(bus.alu_aluop, bus.alu_a, bus.alu_b);

  // Reference result from arithmetic definitions (shifts as multiply/divide by 2**sh).
  function automatic logic [31:0] ref_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] p;
    logic [31:0] q;
    p = 32'h1 << b[4:0];
    q = a / p;
    case (op)
      3'b000:  return a + b;
      3'b001:  return a * p;
      3'b010:  return a[31] ? (q | ~(32'hFFFF_FFFF / p)) : q;
      3'b011:  return a - b;
      3'b100:  return a ^ b;
      3'b101:  return q;
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  // Scoreboard: one entry per accepted request, removed when its response is popped.
  alu_resp_t       sb_q[$];
  int              ptr_m = 0;
  logic [NREQ-1:0] hs_mask = '0;
  logic [NREQ-1:0] exp_rdy;
  int              fire_i;
  int              kk;
  bit              found;
  int              resp_count = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      ptr_m   = 0;
      hs_mask = '0;
    end else begin
      fire_i  = int'(bus.resp_valid & bus.resp_ready);
      exp_rdy = '0;
      found   = 1'b0;
      if (int'(sb_q.size()) - fire_i < 2) begin
        for (int i = 0; i < NREQ; i++) begin
          kk = (ptr_m + i) % NREQ;
          if (!found && bus.req_valid[kk]) begin
            found       = 1'b1;
            exp_rdy[kk] = 1'b1;
          end
        end
      end
      check("arb_ready", 64'(bus.req_ready), 64'(exp_rdy));
      if (fire_i != 0) begin
        resp_count++;
        if (sb_q.size() == 0) begin
          check("resp_unexpected", 64'(bus.resp_valid), 64'(0));
        end else begin
          check("sb_resp_id", 64'(bus.resp_id), 64'(sb_q[0].id));
          check("sb_resp_f", 64'(bus.resp_f), 64'(sb_q[0].f));
          void'(sb_q.pop_front());
        end
      end
      hs_mask = bus.req_valid & bus.req_ready;
      for (int i = 0; i < NREQ; i++) begin
        if (hs_mask[i]) begin
          sb_q.push_back('{id: 3'(i), f: ref_f(bus.req_aluop[i], bus.req_a[i], bus.req_b[i])});
          ptr_m = (i + 1) % NREQ;
        end
      end
    end
  end

  typedef struct {
    int unsigned id;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] f;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    step();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    while ((sb_q.size() != 0 || bus.resp_valid) && n < budget) begin
      step();
      n++;
    end
    check("drain_empty", 64'(sb_q.size()), 64'(0));
  endtask

  int   n_hs;
  int   r0;
  logic hs1;

  initial begin
    vecs[0] = '{0, 3'b000, 32'd5,          32'd7,          32'd12};
    vecs[1] = '{1, 3'b010, 32'h8000_0000,  32'h24,         32'hF800_0000};
    vecs[2] = '{2, 3'b101, 32'h8000_0000,  32'h24,         32'h0800_0000};
    vecs[3] = '{3, 3'b011, 32'd3,          32'd5,          32'hFFFF_FFFE};
    vecs[4] = '{0, 3'b100, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0};
    vecs[5] = '{1, 3'b110, 32'h1234_0000,  32'h0000_5678,  32'h1234_5678};
    vecs[6] = '{2, 3'b111, 32'hDEAD_BEEF,  32'hFFFF_0000,  32'hDEAD_0000};
    vecs[7] = '{3, 3'b001, 32'h0000_0001,  32'h0000_003F,  32'h8000_0000};

    // Reset values, with requests asserted to show they are ignored.
    rst_n          = 1'b0;
    bus.req_valid  = '1;
    bus.req_aluop  = '1;
    bus.req_a      = '1;
    bus.req_b      = '1;
    bus.resp_ready = 1'b1;
    #3;
    check("rst_req_ready", 64'(bus.req_ready), 64'(0));
    check("rst_alu_aluop", 64'(bus.alu_aluop), 64'(0));
    check("rst_alu_a", 64'(bus.alu_a), 64'(0));
    check("rst_alu_b", 64'(bus.alu_b), 64'(0));
    check("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
    check("rst_resp_id", 64'(bus.resp_id), 64'(0));
    check("rst_resp_f", 64'(bus.resp_f), 64'(0));
`ifdef ALU_ARB_STALL_CNT_EN
    check("rst_stall_cnt", 64'(stall_cnt), 64'(0));
`endif
    bus.req_valid = '0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    step();

    // Directed single requests: grant in N, nothing in N+1, response in N+2.
    for (int v = 0; v < 8; v++) begin
      bus.req_valid[vecs[v].id] = 1'b1;
      bus.req_aluop[vecs[v].id] = vecs[v].op;
      bus.req_a[vecs[v].id]     = vecs[v].a;
      bus.req_b[vecs[v].id]     = vecs[v].b;
      @(negedge clk);
      check("vec_grant", 64'(bus.req_ready), 64'(1) << vecs[v].id);
      step();
      bus.req_valid = '0;
      @(negedge clk);
      check("vec_lat_n1", 64'(bus.resp_valid), 64'(0));
      step();
      @(negedge clk);
      check("vec_valid", 64'(bus.resp_valid), 64'(1));
      check("vec_id", 64'(bus.resp_id), 64'(vecs[v].id));
      check("vec_f", 64'(bus.resp_f), 64'(vecs[v].f));
      step();
    end

    // Contention: all four valid from reset; grants 0..3, responses back to back from cycle 2.
    reset_dut();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i] = 1'b1;
      bus.req_aluop[i] = 3'b011;
      bus.req_a[i]     = 32'd100;
      bus.req_b[i]     = 32'(i);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 4) check("cont_grant", 64'(bus.req_ready), 64'(1) << c);
      if (c >= 2) begin
        check("cont_valid", 64'(bus.resp_valid), 64'(1));
        check("cont_id", 64'(bus.resp_id), 64'(c - 2));
        check("cont_f", 64'(bus.resp_f), 64'(100 - (c - 2)));
      end
      step();
      if (c < 4) bus.req_valid[c] = 1'b0;
    end
    drain(10);

    // Backpressure: req1 streams with resp_ready low; exactly two issues fit.
    bus.resp_ready   = 1'b0;
    bus.req_valid[1] = 1'b1;
    bus.req_aluop[1] = 3'b000;
    bus.req_a[1]     = 32'd10;
    bus.req_b[1]     = 32'd1;
    n_hs = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      hs1 = bus.req_ready[1];
      if (hs1) n_hs++;
      step();
      if (hs1) bus.req_a[1] = bus.req_a[1] + 32'd1;
    end
    check("bp_issue_count", 64'(n_hs), 64'(2));
    @(negedge clk);
    check("bp_ready_stalled", 64'(bus.req_ready), 64'(0));
    check("bp_fifo_valid", 64'(bus.resp_valid), 64'(1));
    step();
    r0 = resp_count;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("bp_same_cycle_credit", 64'(bus.req_ready), 64'(4'b0010));
    step();
    bus.req_valid[1] = 1'b0;
    drain(10);
    check("bp_resp_count", 64'(resp_count - r0), 64'(3));

    // Reset while one op is in flight and the FIFO holds one entry.
    bus.resp_ready   = 1'b0;
    bus.req_valid[0] = 1'b1;
    bus.req_aluop[0] = 3'b000;
    bus.req_a[0]     = 32'd1;
    bus.req_b[0]     = 32'd1;
    @(negedge clk);
    step();
    bus.req_valid[0] = 1'b0;
    bus.req_valid[2] = 1'b1;
    bus.req_aluop[2] = 3'b011;
    bus.req_a[2]     = 32'd9;
    bus.req_b[2]     = 32'd2;
    @(negedge clk);
    step();
    bus.req_valid = '0;
    check("rstmid_pre_valid", 64'(bus.resp_valid), 64'(1));
    bus.req_valid[3] = 1'b1;
    bus.req_a[3]     = 32'h1234;
    #1;
    rst_n = 1'b0;
    #1;
    check("rstmid_req_ready", 64'(bus.req_ready), 64'(0));
    check("rstmid_alu_a", 64'(bus.alu_a), 64'(0));
    check("rstmid_resp_valid", 64'(bus.resp_valid), 64'(0));
    check("rstmid_resp_id", 64'(bus.resp_id), 64'(0));
    check("rstmid_resp_f", 64'(bus.resp_f), 64'(0));
    bus.req_valid = '0;
    @(negedge clk);
    #2;
    rst_n          = 1'b1;
    bus.resp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("rstmid_no_resp", 64'(bus.resp_valid), 64'(0));
    end
    step();

`ifdef ALU_ARB_STALL_CNT_EN
    reset_dut();
    check("stall_start", 64'(stall_cnt), 64'(0));
    bus.resp_ready   = 1'b0;
    bus.req_valid[0] = 1'b1;
    bus.req_aluop[0] = 3'b100;
    bus.req_a[0]     = 32'hA5;
    bus.req_b[0]     = 32'h5A;
    repeat (10) step();
    check("stall_cnt_10", 64'(stall_cnt), 64'(8));
    drain(10);
`endif

    // Random traffic against the scoreboard; pending requests hold their payload.
    reset_dut();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && !hs_mask[i]) begin
          if ($urandom_range(0, 15) == 0) bus.req_valid[i] = 1'b0;
        end else begin
          bus.req_valid[i] = ($urandom_range(0, 2) != 0);
          bus.req_aluop[i] = 3'($urandom);
          bus.req_a[i]     = $urandom;
          bus.req_b[i]     = $urandom;
        end
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
